// File: rtl/commit_trace_fifo.sv
// Commit-stage trace capture FIFO.
// Records qualifying commits with a sequence tag and counts drops when full.
package commit_trace_fifo_pkg;

    typedef struct packed {
        logic clk;
    } iu_clk_type;

    typedef struct packed {
        logic [15:0] seq;
        logic [5:0]  tid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  flags;
        logic [3:0]  upc;
    } trace_rec_t;

endpackage

module commit_trace_fifo
    import commit_trace_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PID   = 0
) (
    input  iu_clk_type  gclk,
    input  logic        rst,
    input  logic        in_run,
    input  logic        in_dma_mode,
    input  logic        in_icmiss,
    input  logic [5:0]  in_tid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic        in_replay,
    input  logic        in_dcache_replay,
    input  logic        in_annul,
    input  logic        in_ucmode,
    input  logic [3:0]  in_upc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_pid,
    output logic [15:0] out_seq,
    output logic [5:0]  out_tid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [4:0]  out_flags,
    output logic [3:0]  out_upc,
    output logic [6:0]  count,
    output logic [15:0] drop_cnt,
    output logic        overflow,
    input  logic        clr_stat
);

    localparam int AW = $clog2(DEPTH);

    trace_rec_t      mem [DEPTH];
    trace_rec_t      rec;
    trace_rec_t      head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [15:0]     seq;
    logic            capture;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    assign capture = (in_run | in_dma_mode) & ~in_icmiss;
    assign full    = (count == 7'(DEPTH));
    assign pop     = out_valid & out_ready;
    // A pop frees the head slot in the same edge, so a full FIFO still accepts.
    assign push    = capture & (~full | pop);
    assign drop    = capture & full & ~pop;

    always_comb begin
        rec       = '0;
        rec.seq   = seq;
        rec.tid   = in_tid;
        rec.pc    = in_pc;
        rec.inst  = in_inst;
        rec.flags = {in_replay | in_dcache_replay, in_annul,
                     in_dma_mode, in_ucmode, 1'b0};
        rec.upc   = in_upc;
    end

    always_ff @(posedge gclk.clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= rec;
        end
    end

    always_ff @(posedge gclk.clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            seq    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (capture) seq <= seq + 16'd1;
            case ({push, pop})
                2'b10:   count <= count + 7'd1;
                2'b01:   count <= count - 7'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge gclk.clk) begin
        if (rst) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clr_stat) begin
            drop_cnt <= {15'd0, drop};
            overflow <= drop;
        end else if (drop) begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            overflow <= 1'b1;
        end
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (count != 7'd0);
    assign out_pid   = 4'(PID);
    assign out_seq   = head.seq;
    assign out_tid   = head.tid;
    assign out_pc    = head.pc;
    assign out_inst  = head.inst;
    assign out_flags = head.flags;
    assign out_upc   = head.upc;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo.
// Inputs change on falling edges; outputs are checked on falling edges.
module tb_commit_trace_fifo;
    import commit_trace_fifo_pkg::*;

    logic        clk = 1'b0;
    iu_clk_type  gclk;
    logic        rst, in_run, in_dma_mode, in_icmiss;
    logic [5:0]  in_tid;
    logic [31:0] in_pc, in_inst;
    logic        in_replay, in_dcache_replay, in_annul, in_ucmode;
    logic [3:0]  in_upc;
    logic        out_valid, out_ready;
    logic [3:0]  out_pid;
    logic [15:0] out_seq;
    logic [5:0]  out_tid;
    logic [31:0] out_pc, out_inst;
    logic [4:0]  out_flags;
    logic [3:0]  out_upc;
    logic [6:0]  count;
    logic [15:0] drop_cnt;
    logic        overflow, clr_stat;

    int pass_cnt = 0;
    int total = 0;

    assign gclk.clk = clk;
    always #5 clk = ~clk;

    commit_trace_fifo #(.DEPTH(16), .PID(0)) dut (
        .gclk(gclk), .rst(rst), .in_run(in_run), .in_dma_mode(in_dma_mode),
        .in_icmiss(in_icmiss), .in_tid(in_tid), .in_pc(in_pc),
        .in_inst(in_inst), .in_replay(in_replay),
        .in_dcache_replay(in_dcache_replay), .in_annul(in_annul),
        .in_ucmode(in_ucmode), .in_upc(in_upc), .out_valid(out_valid),
        .out_ready(out_ready), .out_pid(out_pid), .out_seq(out_seq),
        .out_tid(out_tid), .out_pc(out_pc), .out_inst(out_inst),
        .out_flags(out_flags), .out_upc(out_upc), .count(count),
        .drop_cnt(drop_cnt), .overflow(overflow), .clr_stat(clr_stat)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_run = 0; in_dma_mode = 0; in_icmiss = 0; in_tid = 0;
        in_pc = 0; in_inst = 0; in_replay = 0; in_dcache_replay = 0;
        in_annul = 0; in_ucmode = 0; in_upc = 0; out_ready = 0;
        clr_stat = 0;
    endtask

    task automatic pulse_reset();
        rst = 1; step(); rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        in_run = 1;
        step(); step();
        rst = 0; in_run = 0;
        total++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid);
        else pass_cnt++;
        total++;
        if (count !== 7'd0) $display("FAIL reset_count got=%0d exp=0", count);
        else pass_cnt++;
        total++;
        if (drop_cnt !== 16'd0 || overflow !== 1'b0)
            $display("FAIL reset_stat got=%0d/%b exp=0/0", drop_cnt, overflow);
        else pass_cnt++;
    endtask

    task automatic test_single();
        in_run = 1; in_pc = 32'h4000_0000; in_inst = 32'h0100_0000;
        in_tid = 6'd3; out_ready = 1;
        step();
        in_run = 0;
        total++;
        if (out_valid !== 1'b1 || count !== 7'd1)
            $display("FAIL single_valid got=%b/%0d exp=1/1", out_valid, count);
        else pass_cnt++;
        total++;
        if (out_pc !== 32'h4000_0000 || out_inst !== 32'h0100_0000 ||
            out_tid !== 6'd3 || out_seq !== 16'd0 || out_flags !== 5'd0 ||
            out_pid !== 4'd0)
            $display("FAIL single_fields got=%h/%h/%0d/%0d/%b exp=40000000/01000000/3/0/00000",
                     out_pc, out_inst, out_tid, out_seq, out_flags);
        else pass_cnt++;
        step();
        total++;
        if (count !== 7'd0 || out_valid !== 1'b0)
            $display("FAIL single_drain got=%0d/%b exp=0/0", count, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_filter();
        in_run = 1; in_icmiss = 1; out_ready = 0;
        step();
        total++;
        if (count !== 7'd0) $display("FAIL filter_icmiss got=%0d exp=0", count);
        else pass_cnt++;
        in_run = 0; in_dma_mode = 1; in_icmiss = 0;
        step();
        in_dma_mode = 0;
        total++;
        if (out_valid !== 1'b1 || out_seq !== 16'd1 || out_flags !== 5'b00100)
            $display("FAIL filter_dma got=%b/%0d/%b exp=1/1/00100",
                     out_valid, out_seq, out_flags);
        else pass_cnt++;
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    task automatic test_fill_drop();
        pulse_reset();
        out_ready = 0;
        for (int i = 0; i < 18; i++) begin
            in_run = 1; in_pc = 32'h1000 + i;
            step();
        end
        in_run = 0;
        total++;
        if (count !== 7'd16) $display("FAIL fill_count got=%0d exp=16", count);
        else pass_cnt++;
        total++;
        if (drop_cnt !== 16'd2 || overflow !== 1'b1)
            $display("FAIL fill_drop got=%0d/%b exp=2/1", drop_cnt, overflow);
        else pass_cnt++;
        out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (out_seq !== 16'(i) || out_pc !== 32'h1000 + i)
                $display("FAIL drain_order got=%0d/%h exp=%0d/%h",
                         out_seq, out_pc, i, 32'h1000 + i);
            else pass_cnt++;
            step();
        end
        total++;
        if (count !== 7'd0) $display("FAIL drain_count got=%0d exp=0", count);
        else pass_cnt++;
        out_ready = 0; in_run = 1;
        step();
        in_run = 0;
        total++;
        if (out_seq !== 16'd18) $display("FAIL seq_after_drop got=%0d exp=18", out_seq);
        else pass_cnt++;
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    task automatic test_full_pushpop();
        for (int i = 0; i < 16; i++) begin
            in_run = 1; step();
        end
        total++;
        if (count !== 7'd16) $display("FAIL pp_fill got=%0d exp=16", count);
        else pass_cnt++;
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_seq !== 16'(19 + k))
                $display("FAIL pp_head got=%0d exp=%0d", out_seq, 19 + k);
            else pass_cnt++;
            step();
            total++;
            if (count !== 7'd16 || drop_cnt !== 16'd2)
                $display("FAIL pp_count got=%0d/%0d exp=16/2", count, drop_cnt);
            else pass_cnt++;
        end
        in_run = 0;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (out_seq !== 16'(23 + i))
                $display("FAIL pp_order got=%0d exp=%0d", out_seq, 23 + i);
            else pass_cnt++;
            step();
        end
        out_ready = 0;
    endtask

    task automatic test_replay_clr();
        in_run = 1; in_dcache_replay = 1;
        step();
        in_run = 0; in_dcache_replay = 0;
        total++;
        if (out_flags !== 5'b10000 || out_seq !== 16'd39)
            $display("FAIL replay_merge got=%b/%0d exp=10000/39", out_flags, out_seq);
        else pass_cnt++;
        out_ready = 1; step(); out_ready = 0;
        clr_stat = 1; step(); clr_stat = 0;
        total++;
        if (drop_cnt !== 16'd0 || overflow !== 1'b0)
            $display("FAIL clr_stat got=%0d/%b exp=0/0", drop_cnt, overflow);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            in_run = 1; step();
        end
        clr_stat = 1;
        step();
        clr_stat = 0; in_run = 0;
        total++;
        if (drop_cnt !== 16'd1 || overflow !== 1'b1)
            $display("FAIL clr_with_drop got=%0d/%b exp=1/1", drop_cnt, overflow);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            in_run = 1; step();
        end
        in_run = 0;
        total++;
        if (count !== 7'd5) $display("FAIL mid_fill got=%0d exp=5", count);
        else pass_cnt++;
        pulse_reset();
        total++;
        if (out_valid !== 1'b0 || count !== 7'd0 || drop_cnt !== 16'd0)
            $display("FAIL mid_reset got=%b/%0d/%0d exp=0/0/0", out_valid, count, drop_cnt);
        else pass_cnt++;
        in_run = 1; in_pc = 32'hABCD_0000;
        step();
        in_run = 0;
        total++;
        if (out_valid !== 1'b1 || out_seq !== 16'd0 || out_pc !== 32'hABCD_0000)
            $display("FAIL mid_seq got=%b/%0d/%h exp=1/0/abcd0000", out_valid, out_seq, out_pc);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single();
        test_filter();
        test_fill_drop();
        test_full_pushpop();
        test_replay_clr();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/commit_trace_fifo.md
COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

Interface
REQ-001 Parameters SHALL be:
  - DEPTH, default 16, FIFO entries; power of two, 4..64.
  - PID, default 0, pipeline ID copied into every record.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - gclk  input  iu_clk_type  clock bundle; all logic on rising edge of gclk.clk.
  - rst  input  1  synchronous active-high reset.
  - in_run  input  1  commit-stage thread running.
  - in_dma_mode  input  1  commit-stage thread in DMA mode.
  - in_icmiss  input  1  commit-stage instruction is an I-cache miss.
  - in_tid  input  6  thread ID.
  - in_pc  input  32  PC.
  - in_inst  input  32  instruction word.
  - in_replay  input  1  pipeline replay.
  - in_dcache_replay  input  1  D-cache replay.
  - in_annul  input  1  annulled.
  - in_ucmode  input  1  microcode mode.
  - in_upc  input  4  microcode PC.
  - out_valid  output  1  head record available.
  - out_ready  input  1  consumer accepts head.
  - out_pid  output  4  PID.
  - out_seq  output  16  capture sequence number.
  - out_tid  output  6  thread ID.
  - out_pc  output  32  PC.
  - out_inst  output  32  instruction word.
  - out_flags  output  5  {replay, annul, dma_mode, ucmode, 0}.
  - out_upc  output  4  microcode PC.
  - count  output  7  entries held.
  - drop_cnt  output  16  dropped captures, saturating.
  - overflow  output  1  sticky drop flag.
  - clr_stat  input  1  clears drop_cnt and overflow.

Function
REQ-003 Capture event SHALL be (in_run | in_dma_mode) & ~in_icmiss, sampled on each rising clock edge when rst=0.
REQ-004 Record replay bit SHALL be in_replay | in_dcache_replay; all other fields SHALL be copied unmodified.
REQ-005 seq SHALL be a 16-bit counter incremented on every capture event, whether the record is stored or dropped; it wraps 0xFFFF->0x0000.
REQ-006 Each record SHALL carry the seq value held before that event's increment, so the first record after reset has seq 0.
REQ-007 A stored record SHALL appear on out_valid/out_* no earlier and no later than the cycle after its capture edge when the FIFO was empty.
REQ-008 A pop SHALL occur when out_valid & out_ready at a rising edge.
REQ-009 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-010 out_* are don't-care while out_valid=0.
REQ-011 Records SHALL leave in strict capture order; read and write pointers SHALL wrap modulo DEPTH.
REQ-012 count SHALL equal stored minus popped entries, range 0..DEPTH, and update every cycle.
REQ-013 Full (count=DEPTH) without a same-cycle pop: the capture SHALL be dropped.
REQ-014 On a drop, drop_cnt SHALL increment, saturating at 0xFFFF, and overflow SHALL set.
REQ-015 Full with a same-cycle pop: the capture SHALL be stored, count SHALL stay at DEPTH, and no drop SHALL occur.
REQ-016 Empty with a same-cycle capture: there SHALL be no pop.
REQ-017 Simultaneous push and pop at count 1..DEPTH-1 SHALL leave count unchanged.
REQ-018 clr_stat=1 SHALL zero drop_cnt and overflow at the next edge; a drop in that same cycle SHALL leave drop_cnt=1 and overflow=1.
REQ-019 The design SHALL have no combinational path from capture inputs to out_*, and no combinational path from out_ready to any output except via registers.

Reset
REQ-020 While rst=1 at an edge, the block SHALL set pointers, count, seq, drop_cnt and overflow to 0 and out_valid to 0, and discard captures.
REQ-021 A capture asserted in the same cycle as rst=1 SHALL neither be stored nor advance seq.
REQ-022 Reset asserted mid-stream SHALL discard all stored records; the first capture after reset SHALL carry seq 0.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  - Single capture: in_run=1, pc=0x40000000, inst=0x01000000, tid=3, out_ready=1 -> out_valid=1 next cycle with same fields, seq=0, count returns to 0.
  - Filter: in_run=1, in_icmiss=1 -> no record, seq unchanged. in_run=0, in_dma_mode=1, in_icmiss=0 -> record with dma flag=1.
  - Fill and drop: DEPTH=16, out_ready=0, 18 captures -> count=16, drop_cnt=2, overflow=1. Drain yields seq 0..15 in order; next capture gets seq 18.
  - Full push+pop: hold count=16, assert capture and out_ready together for 4 cycles -> count stays 16, drop_cnt unchanged, no seq gaps in output.
  - Replay merge: in_replay=0, in_dcache_replay=1 -> replay flag=1. clr_stat pulse clears drop_cnt/overflow to 0.
  - Reset mid-stream: count=5, assert rst one cycle -> out_valid=0, count=0; next capture has seq 0.
